// File: rtl/ram_dma.sv
// ram_dma: byte-wide copy/fill DMA engine mastering port B of the work RAM.
// Define RAM_DMA_IRQ_EN to build the completion interrupt; otherwise irq is tied low.
module ram_dma #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          io_we,
  input  logic          io_re,
  input  logic [2:0]    io_ad,
  input  logic [7:0]    io_din,
  output logic [7:0]    io_dout,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  output logic          mem_ce,
  output logic          mem_wr,
  output logic          busy,
  output logic          irq
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t        state;
  logic [AW-1:0] src, dst, len;
  logic [DW-1:0] fill, dout_q;
  logic          mode, done, aborted, pass;

  logic          ctrl_we, start, abort_req, last;
  logic [AW-1:0] src_inc, dst_inc, len_dec;
  logic [15:0]   src_w, dst_w, len_w;

  assign ctrl_we   = io_we && (io_ad == 3'd6);
  assign start     = ctrl_we && io_din[0];
  assign abort_req = ctrl_we && io_din[2];
  assign last      = (len == AW'(1));
  assign src_inc   = src + AW'(1);
  assign dst_inc   = dst + AW'(1);
  assign len_dec   = len - AW'(1);

  // Read data only arrives during the WR cycle, so a copy write forwards it
  // straight from mem_din; every other cycle drives the registered byte.
  assign mem_dout = pass ? mem_din : dout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      fill    <= '0;
      dout_q  <= '0;
      mode    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      pass    <= 1'b0;
      busy    <= 1'b0;
      mem_ad  <= '0;
      mem_ce  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      if (io_we && !busy) begin
        case (io_ad)
          3'd0:    src[7:0]    <= io_din;
          3'd1:    src[AW-1:8] <= io_din[AW-9:0];
          3'd2:    dst[7:0]    <= io_din;
          3'd3:    dst[AW-1:8] <= io_din[AW-9:0];
          3'd4:    len[7:0]    <= io_din;
          3'd5:    len[AW-1:8] <= io_din[AW-9:0];
          3'd7:    fill        <= DW'(io_din);
          default: ;
        endcase
      end

      case (state)
        IDLE, FIN: begin
          state  <= IDLE;
          mem_ce <= 1'b0;
          mem_wr <= 1'b0;
          pass   <= 1'b0;
          if (start) begin
            aborted <= 1'b0;
            mode    <= io_din[1];
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              done   <= 1'b0;
              busy   <= 1'b1;
              mem_ce <= 1'b1;
              if (io_din[1]) begin
                state  <= WR;
                mem_ad <= dst;
                mem_wr <= 1'b1;
                dout_q <= fill;
              end else begin
                state  <= RD;
                mem_ad <= src;
              end
            end
          end
        end

        RD: begin
          if (abort_req) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            mem_ce  <= 1'b0;
          end else begin
            state  <= WR;
            mem_ad <= dst;
            mem_wr <= 1'b1;
            pass   <= 1'b1;
          end
        end

        WR: begin
          if (!mode) src <= src_inc;
          dst <= dst_inc;
          len <= len_dec;
          if (last || abort_req) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= abort_req;
            mem_ce  <= 1'b0;
            mem_wr  <= 1'b0;
            pass    <= 1'b0;
          end else if (mode) begin
            mem_ad <= dst_inc;
          end else begin
            state  <= RD;
            mem_ad <= src_inc;
            mem_wr <= 1'b0;
            pass   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign src_w = 16'(src);
  assign dst_w = 16'(dst);
  assign len_w = 16'(len);

  always_comb begin
    io_dout = '0;
    case (io_ad)
      3'd0: io_dout = src_w[7:0];
      3'd1: io_dout = src_w[15:8];
      3'd2: io_dout = dst_w[7:0];
      3'd3: io_dout = dst_w[15:8];
      3'd4: io_dout = len_w[7:0];
      3'd5: io_dout = len_w[15:8];
      3'd6: io_dout = {6'b0, mode, busy};
      3'd7: io_dout = {5'b0, aborted, done, busy};
      default: io_dout = '0;
    endcase
  end

`ifdef RAM_DMA_IRQ_EN
  logic fin_entry, irq_clr;

  always_comb begin
    fin_entry = 1'b0;
    case (state)
      IDLE, FIN: fin_entry = start && (len == '0);
      RD:        fin_entry = abort_req;
      WR:        fin_entry = last || abort_req;
      default:   fin_entry = 1'b0;
    endcase
  end

  assign irq_clr = (io_re && (io_ad == 3'd7)) || (ctrl_we && io_din[3]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       irq <= 1'b0;
    else if (fin_entry) irq <= 1'b1;
    else if (irq_clr)   irq <= 1'b0;
  end
`else
  logic unused_io_re;
  assign unused_io_re = io_re;
  assign irq = 1'b0;
`endif

endmodule
